// File: rtl/mmio_responder_pkg.sv
// Shared constants for mmio_responder: register word offsets (decoded from wa[5:0])
// and status register bit positions.
package mmio_responder_pkg;

  localparam logic [5:0] OFF_STATUS  = 6'h00;  // byte 0x00
  localparam logic [5:0] OFF_RX_DATA = 6'h01;  // byte 0x04
  localparam logic [5:0] OFF_TX_DATA = 6'h02;  // byte 0x08
  localparam logic [5:0] OFF_CYC_CNT = 6'h04;  // byte 0x10
  localparam logic [5:0] OFF_INS_CNT = 6'h05;  // byte 0x14
  localparam logic [5:0] OFF_CNT_CLR = 6'h06;  // byte 0x18

  localparam int STAT_TX_NFULL = 0;
  localparam int STAT_RX_FULL  = 1;

  function automatic logic is_write(input logic [3:0] be);
    return |be;
  endfunction

endpackage

// File: rtl/mmio_responder_sync_fifo.sv
// Small synchronous FIFO with a combinational head output; DEPTH must be a power of two.
// A pop in the same cycle as a push on a full FIFO frees the slot for that push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == CNT_FULL);
  assign empty = (r_count == '0);

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: UART TX FIFO / RX holding register, status, and optional cycle and
// instruction counters (enabled by defining MMIO_COUNTERS_EN).
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RESP_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  we,
  input  logic [13:0] wa,
  input  logic [31:0] wd,
  output logic [31:0] rdata,
  input  logic        inst_retire,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  if (RESP_LAT != 1) begin : g_lat_check
    $error("mmio_responder: only RESP_LAT=1 is supported");
  end

  logic [5:0]  w_off;
  logic        w_rd;
  logic        w_wr;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic        w_rx_pop;
  logic        w_cnt_clr;
  logic [31:0] w_cyc_cnt;
  logic [31:0] w_ins_cnt;
  logic [31:0] w_rd_val;
  logic [31:0] r_rdata;
  logic        r_rx_full;
  logic [7:0]  r_rx_data;
  logic        w_unused;

  assign w_off     = wa[5:0];
  assign w_wr      = en & is_write(we);
  assign w_rd      = en & ~is_write(we);
  assign w_tx_push = en & we[0] & (w_off == OFF_TX_DATA);
  assign w_rx_pop  = w_rd & (w_off == OFF_RX_DATA);
  assign w_cnt_clr = w_wr & (w_off == OFF_CNT_CLR);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .din   (wd[7:0]),
    .dout  (tx_data),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

  assign tx_valid = ~w_tx_empty;
  assign w_tx_pop = tx_valid & tx_ready;

  // rx_ready looks only at the registered flag, so a byte offered in the pop cycle waits one cycle.
  assign rx_ready = ~r_rx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_full <= 1'b0;
      r_rx_data <= '0;
    end else if (w_rx_pop && r_rx_full) begin
      r_rx_full <= 1'b0;
    end else if (rx_valid && rx_ready) begin
      r_rx_full <= 1'b1;
      r_rx_data <= rx_data;
    end
  end

`ifdef MMIO_COUNTERS_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_ins_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc_cnt <= '0;
      r_ins_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cyc_cnt <= '0;
      r_ins_cnt <= '0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (inst_retire) r_ins_cnt <= r_ins_cnt + 32'd1;
    end
  end

  assign w_cyc_cnt = r_cyc_cnt;
  assign w_ins_cnt = r_ins_cnt;
  assign w_unused  = ^{wa[13:6], wd[31:8]};
`else
  assign w_cyc_cnt = '0;
  assign w_ins_cnt = '0;
  assign w_unused  = ^{wa[13:6], wd[31:8], inst_retire, w_cnt_clr};
`endif

  always_comb begin
    w_rd_val = '0;
    case (w_off)
      OFF_STATUS: begin
        w_rd_val[STAT_TX_NFULL] = ~w_tx_full;
        w_rd_val[STAT_RX_FULL]  = r_rx_full;
      end
      OFF_RX_DATA: w_rd_val = r_rx_full ? {24'd0, r_rx_data} : 32'd0;
      OFF_CYC_CNT: w_rd_val = w_cyc_cnt;
      OFF_INS_CNT: w_rd_val = w_ins_cnt;
      default:     w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rd_val;
  end

  assign rdata = r_rdata;

endmodule
